// File: rtl/otfs_pkg.sv
// Shared OTFS receive-path constants: 4QAM symbol geometry, symbol-index
// encoding and the byte-FIFO entry layout.
package otfs_pkg;

  localparam int QAM_BITS      = 2;
  localparam int SYMS_PER_BYTE = 4;
  localparam int BYTE_W        = 8;

  typedef enum logic [1:0] {
    SYM_RE_NEG_IM_POS = 2'd0,
    SYM_RE_NEG_IM_NEG = 2'd1,
    SYM_RE_POS_IM_POS = 2'd2,
    SYM_RE_POS_IM_NEG = 2'd3
  } qam4_sym_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } byte_entry_t;

  // Newest symbol always enters at the LSBs so the first symbol ends up at [7:6].
  function automatic logic [BYTE_W-1:0] pack_sym(
    input logic [BYTE_W-QAM_BITS-1:0] partial,
    input qam4_sym_e                  sym
  );
    return {partial, sym};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: the head entry is visible on
// head_data whenever empty is low. DEPTH must be a power of two.
module sync_fifo_fwft #(
  parameter int WIDTH   = 9,
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = 5
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head_data,
  output logic               empty,
  output logic               full,
  output logic [LEVEL_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [LEVEL_W-1:0] level_r;
  logic               empty_s;
  logic               full_s;
  logic               do_push_s;
  logic               do_pop_s;

  // Status flags and qualified push/pop; a push into a full FIFO is
  // accepted only when a pop frees the slot at the same edge.
  always_comb begin
    empty_s   = (level_r == {LEVEL_W{1'b0}});
    full_s    = (level_r == LEVEL_W'(DEPTH));
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && !empty_s) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && (!full_s || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LEVEL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LEVEL_W'(1);
        2'b01:   level_r <= level_r - LEVEL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign empty     = empty_s;
  assign full      = full_s;
  assign level     = level_r;

endmodule

// File: rtl/qam_symbol_packer_4qam.sv
// Packs 4QAM symbol indices MSB-first into bytes, tags frame-final bytes and
// buffers them in an FWFT FIFO. Optional macro PACKER_OVF_CNT_EN adds OverflowCount.
module qam_symbol_packer_4qam
  import otfs_pkg::*;
#(
  parameter int SYMS_PER_FRAME = 64,
  parameter int FIFO_DEPTH     = 16,
  parameter int LEVEL_W        = 5
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               QAMDemodDataValid,
  input  logic [4:0]         QAMDemodData,
  output logic               ByteValid,
  input  logic               ByteReady,
  output logic [7:0]         ByteData,
  output logic               ByteLast,
  output logic [LEVEL_W-1:0] FifoLevel,
  output logic               Overflow
`ifdef PACKER_OVF_CNT_EN
  ,
  output logic [15:0]        OverflowCount
`endif
);

  localparam int                 FRAME_W      = $clog2(SYMS_PER_FRAME);
  localparam int                 PART_W       = BYTE_W - QAM_BITS;
  localparam logic [FRAME_W-1:0] FRAME_LAST   = FRAME_W'(SYMS_PER_FRAME - 1);
  localparam logic [1:0]         SYM_CNT_LAST = 2'(SYMS_PER_BYTE - 1);

  logic [1:0]         sym_cnt_r;
  logic [FRAME_W-1:0] frame_cnt_r;
  logic [PART_W-1:0]  shift_r;
  logic               overflow_r;

  qam4_sym_e          sym_s;
  logic               byte_done_s;
  logic               pop_s;
  logic               drop_s;
  byte_entry_t        push_entry_s;
  byte_entry_t        head_entry_s;
  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic [LEVEL_W-1:0] fifo_level_s;

  // Byte completion, FIFO handshake and drop detection.
  always_comb begin
    sym_s             = qam4_sym_e'(QAMDemodData[1:0]);
    push_entry_s.data = pack_sym(shift_r, sym_s);
    push_entry_s.last = (frame_cnt_r == FRAME_LAST);
    pop_s             = !fifo_empty_s && ByteReady;
    if (QAMDemodDataValid && (sym_cnt_r == SYM_CNT_LAST)) begin
      byte_done_s = 1'b1;
    end else begin
      byte_done_s = 1'b0;
    end
    if (byte_done_s && fifo_full_s && !pop_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Partial-byte shifter and symbol/frame counters; they advance even when
  // the completed byte is dropped so frame alignment survives an overflow.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      shift_r     <= {PART_W{1'b0}};
      sym_cnt_r   <= 2'd0;
      frame_cnt_r <= {FRAME_W{1'b0}};
    end else if (QAMDemodDataValid) begin
      if (sym_cnt_r == SYM_CNT_LAST) begin
        shift_r   <= {PART_W{1'b0}};
        sym_cnt_r <= 2'd0;
      end else begin
        shift_r   <= {shift_r[PART_W-QAM_BITS-1:0], sym_s};
        sym_cnt_r <= sym_cnt_r + 2'd1;
      end
      if (frame_cnt_r == FRAME_LAST) begin
        frame_cnt_r <= {FRAME_W{1'b0}};
      end else begin
        frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
      end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

`ifdef PACKER_OVF_CNT_EN
  logic [15:0] ovf_cnt_r;

  // Saturating dropped-byte counter.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      ovf_cnt_r <= 16'd0;
    end else if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 16'd1;
    end
  end

  assign OverflowCount = ovf_cnt_r;
`endif

  sync_fifo_fwft #(
    .WIDTH   ($bits(byte_entry_t)),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .Clk       (Clk),
    .RstN      (RstN),
    .push      (byte_done_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head_data (head_entry_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .level     (fifo_level_s)
  );

  assign ByteValid = !fifo_empty_s;
  assign ByteData  = head_entry_s.data;
  assign ByteLast  = head_entry_s.last;
  assign FifoLevel = fifo_level_s;
  assign Overflow  = overflow_r;

endmodule

// File: tb/tb_qam_symbol_packer_4qam.sv
// Self-checking bench: table of byte vectors plus hand-written sequences for
// full/pop collision, overflow and mid-byte reset; bytes scored via a queue.
module tb_qam_symbol_packer_4qam;

  logic       Clk = 1'b0;
  logic       RstN;
  logic       QAMDemodDataValid;
  logic [4:0] QAMDemodData;
  logic       ByteValid;
  logic       ByteReady;
  logic [7:0] ByteData;
  logic       ByteLast;
  logic [2:0] FifoLevel;
  logic       Overflow;
`ifdef PACKER_OVF_CNT_EN
  logic [15:0] OverflowCount;
`endif

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [4:0] s0, s1, s2, s3;
    int         gap;
    logic [7:0] data;
    logic       last;
  } vec_t;

  vec_t vecs[6];

  qam_symbol_packer_4qam #(
    .SYMS_PER_FRAME (8),
    .FIFO_DEPTH     (4),
    .LEVEL_W        (3)
  ) dut (
    .Clk               (Clk),
    .RstN              (RstN),
    .QAMDemodDataValid (QAMDemodDataValid),
    .QAMDemodData      (QAMDemodData),
    .ByteValid         (ByteValid),
    .ByteReady         (ByteReady),
    .ByteData          (ByteData),
    .ByteLast          (ByteLast),
    .FifoLevel         (FifoLevel),
    .Overflow          (Overflow)
`ifdef PACKER_OVF_CNT_EN
    ,
    .OverflowCount     (OverflowCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare the head whenever the next edge will pop it.
  always @(negedge Clk) begin
    if (RstN && ByteValid && ByteReady) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %0h expected none", {ByteLast, ByteData});
      end else begin
        check("sb_byte", {23'd0, ByteLast, ByteData}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic drive_sym(input logic [4:0] d);
    QAMDemodDataValid = 1'b1;
    QAMDemodData      = d;
    tick(1);
    QAMDemodDataValid = 1'b0;
    QAMDemodData      = 5'd0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input bit drop,
                           input bit ready_on_last);
    logic [7:0] v;
    v = b;
    if (!drop) exp_q.push_back({last, b});
    drive_sym({3'b000, v[7:6]});
    drive_sym({3'b000, v[5:4]});
    drive_sym({3'b000, v[3:2]});
    if (ready_on_last) ByteReady = 1'b1;
    drive_sym({3'b000, v[1:0]});
    if (ready_on_last) ByteReady = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ByteValid) && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, ByteValid, 0);
    check({tag, "_data"}, ByteData, 0);
    check({tag, "_last"}, ByteLast, 0);
    check({tag, "_level"}, FifoLevel, 0);
    check({tag, "_ovf"}, Overflow, 0);
`ifdef PACKER_OVF_CNT_EN
    check({tag, "_ovfcnt"}, OverflowCount, 0);
`endif
  endtask

  initial begin
    // Frame = 8 symbols = 2 bytes, so expected Last alternates 0,1.
    vecs[0] = '{5'd3, 5'd3, 5'd3, 5'd3, 2, 8'hFF, 1'b0};
    vecs[1] = '{5'd0, 5'd0, 5'd0, 5'd0, 2, 8'h00, 1'b1};
    vecs[2] = '{5'd2, 5'd3, 5'd0, 5'd1, 0, 8'hB1, 1'b0};
    vecs[3] = '{5'b11110, 5'b00101, 5'b01000, 5'b10011, 0, 8'h93, 1'b1};
    vecs[4] = '{5'd1, 5'd1, 5'd1, 5'd1, 1, 8'h55, 1'b0};
    vecs[5] = '{5'd3, 5'd2, 5'd1, 5'd0, 0, 8'hE4, 1'b1};

    RstN              = 1'b0;
    QAMDemodDataValid = 1'b0;
    QAMDemodData      = 5'd0;
    ByteReady         = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    RstN = 1'b1;

    ByteReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].last, vecs[i].data});
      drive_sym(vecs[i].s0);
      tick(vecs[i].gap);
      drive_sym(vecs[i].s1);
      tick(vecs[i].gap);
      drive_sym(vecs[i].s2);
      tick(vecs[i].gap);
      drive_sym(vecs[i].s3);
      check("vec_latency_valid", ByteValid, 1);
      check("vec_data", ByteData, vecs[i].data);
      check("vec_last", ByteLast, vecs[i].last);
      check("vec_level", FifoLevel, 1);
      tick(2);
    end
    wait_drain();

    // Fill to full, then complete a byte in the same cycle as a pop.
    ByteReady = 1'b0;
    send_byte(8'hBC, 1'b0, 1'b0, 1'b0);
    send_byte(8'hDE, 1'b1, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b1, 1'b0, 1'b0);
    check("full_level", FifoLevel, 4);
    send_byte(8'h5A, 1'b0, 1'b0, 1'b1);
    check("pushpop_level", FifoLevel, 4);
    check("pushpop_ovf", Overflow, 0);
    check("pushpop_head", ByteData, 8'hDE);
`ifdef PACKER_OVF_CNT_EN
    check("pushpop_ovfcnt", OverflowCount, 0);
`endif
    ByteReady = 1'b1;
    wait_drain();

    // Overflow: fifth byte dropped, flag sticky, frame alignment kept.
    ByteReady = 1'b0;
    send_byte(8'h12, 1'b1, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0, 1'b0);
    send_byte(8'h56, 1'b1, 1'b0, 1'b0);
    send_byte(8'h78, 1'b0, 1'b0, 1'b0);
    check("prefill_ovf", Overflow, 0);
    send_byte(8'h9A, 1'b1, 1'b1, 1'b0);
    check("ovf_level", FifoLevel, 4);
    check("ovf_flag", Overflow, 1);
    check("ovf_head", ByteData, 8'h12);
`ifdef PACKER_OVF_CNT_EN
    check("ovf_count", OverflowCount, 1);
`endif
    tick(3);
    check("ovf_sticky", Overflow, 1);
    ByteReady = 1'b1;
    wait_drain();
    check("ovf_sticky_drained", Overflow, 1);
    send_byte(8'hAB, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Reset mid-byte discards partial data and restarts the frame.
    drive_sym(5'd1);
    drive_sym(5'd2);
    RstN = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    RstN = 1'b1;
    send_byte(8'h1B, 1'b0, 1'b0, 1'b0);
    wait_drain();
    send_byte(8'h2C, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("final_level", FifoLevel, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
